// File: rtl/data_ram.sv
// Data memory for the MEM stage: byte-lane writes posted through a one-entry
// buffer that drains one cycle later, and combinational reads that forward buffered bytes.
module data_ram #(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_raddr_i,
    output logic [31:0] mem_rdata_o,
    input  logic [31:0] mem_waddr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_we_i,
    output logic        addr_err_o,
    output logic [15:0] wr_cnt_o,
    output logic        idle_o
);
    localparam int          AW     = $clog2(DEPTH);
    localparam logic [29:0] BASE_W = BASE_ADDR[31:2];

    logic [31:0] mem [DEPTH];

    logic          wb_valid;
    logic [AW-1:0] wb_idx;
    logic [3:0]    wb_be;
    logic [31:0]   wb_data;

    logic [29:0]   w_word;
    logic [29:0]   r_word;
    logic          w_in_range;
    logic          r_in_range;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] r_idx;
    logic          unused_addr_lsbs;

    // Byte offsets inside a word do not take part in indexing.
    assign unused_addr_lsbs = ^{mem_waddr_i[1:0], mem_raddr_i[1:0]};

    assign w_word     = mem_waddr_i[31:2] - BASE_W;
    assign r_word     = mem_raddr_i[31:2] - BASE_W;
    assign w_in_range = (mem_waddr_i[31:2] >= BASE_W) && (w_word[29:AW] == '0);
    assign r_in_range = (mem_raddr_i[31:2] >= BASE_W) && (r_word[29:AW] == '0);
    assign w_idx      = w_word[AW-1:0];
    assign r_idx      = r_word[AW-1:0];

    // Array is not reset; a buffered write pending at reset is discarded.
    always_ff @(posedge clk) begin
        if (!rst && wb_valid) begin
            for (int k = 0; k < 4; k++) begin
                if (wb_be[k]) begin
                    mem[wb_idx][8*k +: 8] <= wb_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            wb_idx     <= '0;
            wb_be      <= '0;
            wb_data    <= '0;
            addr_err_o <= 1'b0;
            wr_cnt_o   <= 16'h0000;
        end else begin
            wb_valid <= 1'b0;
            if (mem_we_i != 4'b0000) begin
                if (w_in_range) begin
                    wb_valid <= 1'b1;
                    wb_idx   <= w_idx;
                    wb_be    <= mem_we_i;
                    wb_data  <= mem_wdata_i;
                    wr_cnt_o <= wr_cnt_o + 16'd1;
                end else begin
                    addr_err_o <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        mem_rdata_o = 32'h0000_0000;
        if (r_in_range) begin
            mem_rdata_o = mem[r_idx];
            for (int k = 0; k < 4; k++) begin
                if (wb_valid && (wb_idx == r_idx) && wb_be[k]) begin
                    mem_rdata_o[8*k +: 8] = wb_data[8*k +: 8];
                end
            end
        end
    end

    assign idle_o = ~wb_valid;

endmodule
